decode: RTL

Decode stage of the pipelined MIPS core, directly downstream of `fetch`. Holds the IF/ID pipeline register, reads and writes the 32×32 register file, and generates main and ALU control. Resolves `beq`/`bne` and `j` early in D with M-stage forwarding. Returns `pcsrcD`, `branchD`, `jumpD` and `pcbranchD` to `fetch`, the branch predictor and the instruction cache.

---
 rtl/decode_pkg.sv | 72 +++++++
 rtl/decode_regfile.sv | 41 ++++
 rtl/decode.sv | 135 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode, funct, ALU-control encodings and control decode for the MIPS decode stage
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Bit positions inside branchD
  localparam int BR_BEQ = 0;
  localparam int BR_BNE = 1;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       jump;
    logic [1:0] branch;
    logic [2:0] alucontrol;
    logic       zext;
  } ctrl_t;

  // Main + ALU control; unknown opcode or funct leaves every field at 0
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  begin c.regwrite = 1'b1; c.regdst = 1'b1; c.alucontrol = ALU_ADD; end
          FN_SUB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; c.alucontrol = ALU_SUB; end
          FN_AND:  begin c.regwrite = 1'b1; c.regdst = 1'b1; c.alucontrol = ALU_AND; end
          FN_OR:   begin c.regwrite = 1'b1; c.regdst = 1'b1; c.alucontrol = ALU_OR;  end
          FN_SLT:  begin c.regwrite = 1'b1; c.regdst = 1'b1; c.alucontrol = ALU_SLT; end
          default: c = '0;
        endcase
      end
      OP_LW:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_ADD; end
      OP_SW:   begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_ADD; end
      OP_BEQ:  begin c.branch[BR_BEQ] = 1'b1; c.alucontrol = ALU_SUB; end
      OP_BNE:  begin c.branch[BR_BNE] = 1'b1; c.alucontrol = ALU_SUB; end
      OP_ADDI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_ADD; end
      OP_ANDI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_AND; c.zext = 1'b1; end
      OP_ORI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_OR;  c.zext = 1'b1; end
      OP_SLTI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_SLT; end
      OP_J:    c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 32x32 register file, one write port, two combinational read ports with write bypass
module regfile
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next register contents: $0 is never written
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  // Register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // $0 reads zero; a same-cycle write to the read register is bypassed
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (we && (wa == ra1)) rd1 = wd;
    if (we && (wa == ra2)) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - MIPS decode stage: IF/ID register, register file, control decode, early branch/jump resolution
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrF,
  input  logic [31:0] pcplus4F,
  input  logic        predict_takenF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        forwardAD,
  input  logic        forwardBD,
  input  logic [31:0] aluoutM,
  input  logic        regwriteW,
  input  logic [4:0]  writeregW,
  input  logic [31:0] resultW,
  output logic        pcsrcD,
  output logic [1:0]  branchD,
  output logic        jumpD,
  output logic        mispredictD,
  output logic [31:0] pcbranchD,
  output logic [31:0] pcjumpD,
  output logic        regwriteD,
  output logic        memtoregD,
  output logic        memwriteD,
  output logic        alusrcD,
  output logic        regdstD,
  output logic [2:0]  alucontrolD,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [31:0] immD,
  output logic [31:0] pcplus4D,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        predict_q, predict_d;
  logic        valid_q, valid_d;

  ctrl_t       ctrl;
  logic [31:0] simm;
  logic [31:0] src_a, src_b;
  logic        eq;
  logic        taken;

  // IF/ID next state: stall holds (and swallows a simultaneous flush), flush bubbles, else load
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    predict_d = predict_q;
    valid_d   = valid_q;
    if (stallD) begin
      instr_d = instr_q;
    end else if (flushD) begin
      instr_d   = '0;
      pcplus4_d = '0;
      predict_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      instr_d   = instrF;
      pcplus4_d = pcplus4F;
      predict_d = predict_takenF;
      valid_d   = 1'b1;
    end
  end

  // IF/ID register; reset wins over stall
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
      predict_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      predict_q <= predict_d;
      valid_q   <= valid_d;
    end
  end

  assign rsD      = instr_q[25:21];
  assign rtD      = instr_q[20:16];
  assign rdD      = instr_q[15:11];
  assign pcplus4D = pcplus4_q;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwriteW),
    .wa    (writeregW),
    .wd    (resultW),
    .ra1   (rsD),
    .ra2   (rtD),
    .rd1   (rd1D),
    .rd2   (rd2D)
  );

  // Control decode of the held instruction
  always_comb begin
    ctrl = decode_ctrl(instr_q[31:26], instr_q[5:0]);
  end

  assign simm      = {{16{instr_q[15]}}, instr_q[15:0]};
  assign immD      = ctrl.zext ? {16'h0000, instr_q[15:0]} : simm;
  assign pcbranchD = pcplus4_q + {simm[29:0], 2'b00};
  assign pcjumpD   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};

  // Early branch compare with M-stage forwarding
  always_comb begin
    src_a = forwardAD ? aluoutM : rd1D;
    src_b = forwardBD ? aluoutM : rd2D;
    eq    = (src_a == src_b);
    taken = (ctrl.branch[BR_BEQ] & eq) | (ctrl.branch[BR_BNE] & ~eq);
  end

  // Control outputs; a bubble forces every side-effecting control to 0
  always_comb begin
    regwriteD   = valid_q & ctrl.regwrite;
    memtoregD   = valid_q & ctrl.memtoreg;
    memwriteD   = valid_q & ctrl.memwrite;
    branchD     = valid_q ? ctrl.branch : 2'b00;
    jumpD       = valid_q & ctrl.jump;
    pcsrcD      = valid_q & taken;
    mispredictD = valid_q & (|ctrl.branch) & (taken != predict_q);
    alusrcD     = ctrl.alusrc;
    regdstD     = ctrl.regdst;
    alucontrolD = ctrl.alucontrol;
  end

endmodule
